matrix_seq: RTL and testbench
=============================

# matrix_seq

Command sequencer for the matrix coprocessor. It accepts one matrix command from the host and walks the operand matrices element by element, reading operand memories A and B. It drives the combinational `alu` with per-element operands, then writes results to result memory C. It owns all iteration, accumulation and handshake logic; the `alu` stays purely combinational.

## Interface
Parameters:
- `DW`, 8, element width (signed two's complement)
- `MAXN`, 5, maximum matrix dimension; storage row stride is fixed at `MAXN`
- `AW`, 5, memory address width; `addr = row*MAXN + col`

Ports:
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: reset, asynchronous and active-low
- `start` in 1: command request; sampled only in IDLE
- `op` in 3: opcode. 000 add, 001 sub, 010 mult, 011 mult-by-scalar, 100 det, 101 transpose, 110 opposite, 111 clear
- `size` in 3: matrix dimension n
- `scalar` in DW: scalar operand for op 011
- `busy` out 1: high from the cycle after `start` is accepted until `done`
- `done` out 1: one-cycle pulse at command end
- `err` out 1: valid with `done`; 1 means the command was rejected
- `a_addr` out AW, `a_data` in DW: memory A read port, synchronous, 1-cycle latency
- `b_addr` out AW, `b_data` in DW: memory B read port, synchronous, 1-cycle latency
- `c_addr` out AW, `c_data` out DW, `c_we` out 1: memory C write port
- `alu_op` out 3, `alu_r1` out DW, `alu_r2` out DW, `alu_s` out 3: drive the `alu`
- `alu_res` in DW: combinational result from the `alu`

## Operation
- On `start` in IDLE, latch `op`, `size` and `scalar` into internal registers. Later changes to the inputs have no effect.
- The command is rejected when `size` is 0, `size` > MAXN, or `op` = 100 (det is not supported by the sequencer). Rejection goes IDLE→DONE with `err`=1 and no memory writes.
- States: IDLE, RD, EX, DONE.
  - RD: present read addresses.
  - EX: read data is valid; drive `alu_*`; capture `alu_res`.
  - DONE: pulse `done`, then return to IDLE.
- Element-wise ops (000, 001, 011, 110):
  - For each (i,j) in row-major order: RD with `a_addr=b_addr=i*MAXN+j`.
  - In EX: `alu_r1=a_data`; `alu_r2` is `b_data`, or `scalar` for op 011.
  - Write `c_addr=i*MAXN+j`, `c_data=alu_res`, `c_we`=1 in the same EX cycle.
- Transpose (101): read A at `j*MAXN+i` and write C at `i*MAXN+j`. `alu_r1=a_data`; `alu_r2` is 0.
- Mult (010): for each (i,j), loop k=0..n-1.
  - RD with `a_addr=i*MAXN+k`, `b_addr=k*MAXN+j`.
  - EX: `acc <= (k==0 ? 0 : acc) + alu_res`, mod 2^DW (wrap, no saturation).
  - On k=n-1, write the summed value to C at (i,j) in that EX cycle.
- Clear (111): no reads. Write 0 to every C element (i,j < n) using the same RD/EX cadence.
- `alu_op` = latched op and `alu_s` = latched size whenever `busy`. Both are 0 in IDLE.
- `start` while `busy` is ignored and not queued.

## Timing
- Reset values (asynchronous): state IDLE. `busy`, `done`, `err`, `c_we` are 0. All addresses, `c_data`, and `alu_*` outputs are 0. Counters and accumulator are 0.
- `start` accepted at edge T0: `busy`=1 from T0; the first RD cycle is T0→T1.
- Element-wise, transpose and clear: `2*n*n` cycles of RD/EX, then DONE for one cycle. `done` is high in cycle `2*n*n+1` after T0.
- Mult: `2*n*n*n` RD/EX cycles, then DONE.
- Rejected command: DONE in the cycle immediately after acceptance.
- `busy` drops in the DONE cycle. A new `start` is accepted in the cycle after DONE.
- `c_we` is asserted only in EX cycles that write. There is never more than one write per cycle.
- Asserting `rst_n` mid-command aborts immediately. No further writes occur; already-written C elements are not restored.

## Structure
- Shared package `matrix_pkg` holds:
  - opcode localparams: ADD, SUB, MULT, MULTR, DET, TRANS, OPP, CLR
  - `DW`, `MAXN`, `AW`
  - the state enum
- The `alu` reuses the same opcode constants from `matrix_pkg`.
- Sub-module `matrix_idx_cnt` is a nested i/j/k counter:
  - inputs: `n`, `use_k`, `step`, `clr`
  - outputs: `i`, `j`, `k`, `last`

## Test plan
- Add, n=2, A=[1,2;3,4], B=[10,20;30,40]: C=[11,22;33,44]. `done` at cycle 9 after start, `err`=0, exactly 4 writes.
- Mult, n=3, A=identity, B=1..9: C=B. Wrap check: A=B=all 16, n=2, gives each C element 0 (512 mod 256).
- Transpose, n=5, A[i][j]=i*5+j: C[i][j]=j*5+i, and C address 24 is written last.
- Reject cases: size=0, size=6, and op=100 each give `done` with `err`=1 one cycle after start, with zero `c_we`.
- `start` pulsed during `busy` is ignored. `rst_n` low mid-mult leaves `c_we`=0, `busy`=0 and all outputs at reset values until the next `start`.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared constants for the matrix coprocessor: sizes, opcodes and sequencer states.
package matrix_pkg;

  localparam int unsigned DW   = 8;
  localparam int unsigned MAXN = 5;
  localparam int unsigned AW   = 5;
  localparam int unsigned CW   = 3;

  localparam logic [2:0] ADD   = 3'b000;
  localparam logic [2:0] SUB   = 3'b001;
  localparam logic [2:0] MULT  = 3'b010;
  localparam logic [2:0] MULTR = 3'b011;
  localparam logic [2:0] DET   = 3'b100;
  localparam logic [2:0] TRANS = 3'b101;
  localparam logic [2:0] OPP   = 3'b110;
  localparam logic [2:0] CLR   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_EX   = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/matrix_idx_cnt.sv
// Nested row/column/inner-product counter, row-major, k innermost when enabled.
module matrix_idx_cnt
  import matrix_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CW-1:0] n,
  input  logic          use_k,
  input  logic          step,
  input  logic          clr,
  output logic [CW-1:0] i,
  output logic [CW-1:0] j,
  output logic [CW-1:0] k,
  output logic          last
);

  logic [CW-1:0] nm1;
  logic          k_end;
  logic          j_end;
  logic          i_end;

  assign nm1   = n - CW'(1);
  assign k_end = !use_k || (k == nm1);
  assign j_end = (j == nm1);
  assign i_end = (i == nm1);
  assign last  = i_end && j_end && k_end;

  // Advance k, then j, then i; wrap to zero after the final element.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i <= '0;
      j <= '0;
      k <= '0;
    end else if (clr) begin
      i <= '0;
      j <= '0;
      k <= '0;
    end else if (step) begin
      if (!k_end) begin
        k <= k + CW'(1);
      end else begin
        k <= '0;
        if (!j_end) begin
          j <= j + CW'(1);
        end else begin
          j <= '0;
          i <= i_end ? '0 : i + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/matrix_seq.sv
// Matrix command sequencer: walks operands through RD/EX cycles, drives the alu, writes C.
module matrix_seq
  import matrix_pkg::*;
#(
  parameter int unsigned DW   = matrix_pkg::DW,
  parameter int unsigned MAXN = matrix_pkg::MAXN,
  parameter int unsigned AW   = matrix_pkg::AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic [2:0]    size,
  input  logic [DW-1:0] scalar,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  output logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_data,
  output logic [AW-1:0] c_addr,
  output logic [DW-1:0] c_data,
  output logic          c_we,
  output logic [2:0]    alu_op,
  output logic [DW-1:0] alu_r1,
  output logic [DW-1:0] alu_r2,
  output logic [2:0]    alu_s,
  input  logic [DW-1:0] alu_res
);

  localparam logic [AW-1:0] STRIDE = AW'(MAXN);

  state_t        state;
  logic [2:0]    op_q;
  logic [2:0]    sz_q;
  logic [DW-1:0] scal_q;
  logic [DW-1:0] acc;
  logic [DW-1:0] sum;
  logic          first_q;
  logic          last_q;
  logic [CW-1:0] ci;
  logic [CW-1:0] cj;
  logic [CW-1:0] ck;
  logic          clast;
  logic          use_k;
  logic          reject;
  logic [AW-1:0] rc_addr;
  logic [AW-1:0] a_nxt;
  logic [AW-1:0] b_nxt;

  assign use_k   = (op_q == MULT);
  assign reject  = (size == 3'd0) || (size > 3'(MAXN)) || (op == DET);
  assign rc_addr = AW'(ci) * STRIDE + AW'(cj);
  assign sum     = (first_q ? '0 : acc) + alu_res;

  matrix_idx_cnt u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .n     (sz_q),
    .use_k (use_k),
    .step  (state == S_RD),
    .clr   ((state == S_IDLE) || (state == S_DONE)),
    .i     (ci),
    .j     (cj),
    .k     (ck),
    .last  (clast)
  );

  // Read addresses for the element the counter currently points at.
  always_comb begin
    a_nxt = rc_addr;
    b_nxt = rc_addr;
    case (op_q)
      MULT: begin
        a_nxt = AW'(ci) * STRIDE + AW'(ck);
        b_nxt = AW'(ck) * STRIDE + AW'(cj);
      end
      TRANS: begin
        a_nxt = AW'(cj) * STRIDE + AW'(ci);
        b_nxt = '0;
      end
      CLR: begin
        a_nxt = '0;
        b_nxt = '0;
      end
      default: ;
    endcase
  end

  // Operand and write data follow the memory read data within the EX cycle.
  always_comb begin
    alu_r1 = '0;
    alu_r2 = '0;
    c_data = '0;
    if (state == S_EX) begin
      alu_r1 = (op_q == CLR) ? '0 : a_data;
      case (op_q)
        MULTR:      alu_r2 = scal_q;
        TRANS, CLR: alu_r2 = '0;
        default:    alu_r2 = b_data;
      endcase
    end
    if (c_we) begin
      case (op_q)
        MULT:    c_data = sum;
        CLR:     c_data = '0;
        default: c_data = alu_res;
      endcase
    end
  end

  // Sequencer FSM with registered handshake, address and alu control outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      op_q    <= '0;
      sz_q    <= '0;
      scal_q  <= '0;
      acc     <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      c_we    <= 1'b0;
      a_addr  <= '0;
      b_addr  <= '0;
      c_addr  <= '0;
      alu_op  <= '0;
      alu_s   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (start) begin
            op_q   <= op;
            sz_q   <= size;
            scal_q <= scalar;
            a_addr <= '0;
            b_addr <= '0;
            if (reject) begin
              state <= S_DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state  <= S_RD;
              busy   <= 1'b1;
              alu_op <= op;
              alu_s  <= size;
            end
          end
        end
        S_RD: begin
          state   <= S_EX;
          c_addr  <= rc_addr;
          c_we    <= !use_k || (ck == sz_q - 3'd1);
          first_q <= (ck == '0);
          last_q  <= clast;
        end
        S_EX: begin
          c_we <= 1'b0;
          if (use_k) acc <= sum;
          if (last_q) begin
            state  <= S_DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            alu_op <= '0;
            alu_s  <= '0;
            a_addr <= '0;
            b_addr <= '0;
            c_addr <= '0;
          end else begin
            state  <= S_RD;
            a_addr <= a_nxt;
            b_addr <= b_nxt;
          end
        end
        default: begin
          state <= S_IDLE;
          done  <= 1'b0;
          err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_seq.sv
// Self-checking bench for matrix_seq with memory, alu and result models.
module tb_matrix_seq;
  import matrix_pkg::*;

  localparam int unsigned OW = 4 + 3 * AW + 3 * DW + 6;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [2:0]    op;
  logic [2:0]    size;
  logic [DW-1:0] scalar;
  logic          busy, done, err, c_we;
  logic [AW-1:0] a_addr, b_addr, c_addr;
  logic [DW-1:0] a_data, b_data, c_data;
  logic [2:0]    alu_op, alu_s;
  logic [DW-1:0] alu_r1, alu_r2, alu_res;
  logic [OW-1:0] outs;

  logic [DW-1:0] ma [32];
  logic [DW-1:0] mb [32];
  logic [DW-1:0] mc [32];
  logic [DW-1:0] ec [32];
  logic          mc_init;
  int            wr_total;
  logic [AW-1:0] last_wr;

  int errors = 0;
  int checks = 0;

  matrix_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .size(size), .scalar(scalar),
    .busy(busy), .done(done), .err(err),
    .a_addr(a_addr), .a_data(a_data), .b_addr(b_addr), .b_data(b_data),
    .c_addr(c_addr), .c_data(c_data), .c_we(c_we),
    .alu_op(alu_op), .alu_r1(alu_r1), .alu_r2(alu_r2), .alu_s(alu_s), .alu_res(alu_res)
  );

  assign outs = {busy, done, err, c_we, a_addr, b_addr, c_addr, c_data,
                 alu_op, alu_r1, alu_r2, alu_s};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Combinational alu behaviour.
  always_comb begin
    case (alu_op)
      ADD:         alu_res = alu_r1 + alu_r2;
      SUB:         alu_res = alu_r1 - alu_r2;
      MULT, MULTR: alu_res = alu_r1 * alu_r2;
      TRANS:       alu_res = alu_r1;
      OPP:         alu_res = -alu_r1;
      default:     alu_res = '0;
    endcase
  end

  // Synchronous operand memories.
  always @(posedge clk) begin
    a_data <= ma[a_addr];
    b_data <= mb[b_addr];
  end

  // Result memory plus write log.
  always @(posedge clk) begin
    if (mc_init) begin
      for (int q = 0; q < 32; q++) mc[q] <= '0;
      wr_total <= 0;
      last_wr  <= '0;
    end else if (c_we) begin
      mc[c_addr] <= c_data;
      wr_total   <= wr_total + 1;
      last_wr    <= c_addr;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mult_elem(input int i, input int j, input int n);
    int s = 0;
    for (int k = 0; k < n; k++) s += int'(ma[i*5+k]) * int'(mb[k*5+j]);
    return DW'(s);
  endfunction

  // Expected C after one command, from the operation definitions.
  task automatic model_cmd(input logic [2:0] o, input int n, input logic [DW-1:0] sc);
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        int av = int'(ma[i*5+j]);
        int bv = int'(mb[i*5+j]);
        case (o)
          ADD:     ec[i*5+j] = DW'(av + bv);
          SUB:     ec[i*5+j] = DW'(av - bv);
          MULT:    ec[i*5+j] = mult_elem(i, j, n);
          MULTR:   ec[i*5+j] = DW'(av * int'(sc));
          TRANS:   ec[i*5+j] = ma[j*5+i];
          OPP:     ec[i*5+j] = DW'(-av);
          default: ec[i*5+j] = '0;
        endcase
      end
  endtask

  task automatic fill_rand();
    for (int q = 0; q < 32; q++) begin
      ma[q] = DW'($urandom);
      mb[q] = DW'($urandom);
    end
  endtask

  task automatic run_cmd(input string tag, input logic [2:0] o, input int n,
                         input logic [DW-1:0] sc, input bit poke);
    bit acc_ok  = (n >= 1) && (n <= 5) && (o != DET);
    int exp_cyc = !acc_ok ? 1 : ((o == MULT) ? 2*n*n*n : 2*n*n) + 1;
    int w0      = wr_total;
    int cyc     = 0;
    int bad     = 0;
    int first   = -1;
    bit got     = 0;
    bit albad   = 0;
    logic b1    = 1'b0;
    if (acc_ok) model_cmd(o, n, sc);
    op = o; size = 3'(n); scalar = sc; start = 1'b1;
    while (!got && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        start = 1'b0; b1 = busy;
        op = 3'($urandom); size = 3'($urandom); scalar = DW'($urandom);
      end
      if (poke && cyc == 3) start = 1'b1;
      if (poke && cyc == 4) start = 1'b0;
      if (busy && (alu_op !== o || alu_s !== 3'(n))) albad = 1;
      if (done) got = 1;
    end
    chk({tag, "_done_seen"}, 64'(got), 64'd1);
    chk({tag, "_done_cyc"}, 64'(cyc), 64'(exp_cyc));
    chk({tag, "_err"}, 64'(err), 64'(!acc_ok));
    chk({tag, "_busy1"}, 64'(b1), 64'(acc_ok));
    chk({tag, "_alu_ctl"}, 64'(albad), 64'd0);
    chk({tag, "_writes"}, 64'(wr_total - w0), 64'(acc_ok ? n*n : 0));
    for (int q = 0; q < 32; q++)
      if (mc[q] !== ec[q]) begin
        bad++;
        if (first < 0) first = q;
      end
    chk({tag, "_cmem_bad"}, 64'(bad), 64'd0);
    if (first >= 0) chk({tag, "_cmem_first"}, 64'(mc[first]), 64'(ec[first]));
    if (acc_ok) chk({tag, "_last_addr"}, 64'(last_wr), 64'((n-1)*5 + n - 1));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'({done, busy}), 64'd0);
    if (poke) begin
      w0 = wr_total;
      repeat (3) @(negedge clk);
      chk({tag, "_poke_idle"}, 64'(busy), 64'd0);
      chk({tag, "_poke_wr"}, 64'(wr_total - w0), 64'd0);
    end
  endtask

  initial begin
    int cyc;
    int w0;
    bit dirty;
    rst_n = 1'b0; start = 1'b0; op = '0; size = '0; scalar = '0; mc_init = 1'b1;
    for (int q = 0; q < 32; q++) ec[q] = '0;
    fill_rand();
    repeat (2) @(negedge clk);
    mc_init = 1'b0;
    chk("reset_outs", 64'(outs), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_outs", 64'(outs), 64'd0);

    // Element-wise add.
    fill_rand();
    ma[0] = 8'd1;  ma[1] = 8'd2;  ma[5] = 8'd3;  ma[6] = 8'd4;
    mb[0] = 8'd10; mb[1] = 8'd20; mb[5] = 8'd30; mb[6] = 8'd40;
    run_cmd("add2", ADD, 2, 8'd0, 0);
    chk("add2_vals", 64'({mc[0], mc[1], mc[5], mc[6]}), 64'({8'd11, 8'd22, 8'd33, 8'd44}));

    // Identity times 1..9.
    fill_rand();
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        ma[i*5+j] = (i == j) ? 8'd1 : 8'd0;
        mb[i*5+j] = DW'(i*3 + j + 1);
      end
    run_cmd("mult_id", MULT, 3, 8'd0, 0);
    chk("mult_id_vals", 64'({mc[0], mc[6], mc[12], mc[2]}), 64'({8'd1, 8'd5, 8'd9, 8'd3}));

    // Accumulator wrap.
    for (int q = 0; q < 32; q++) begin ma[q] = 8'd16; mb[q] = 8'd16; end
    run_cmd("mult_wrap", MULT, 2, 8'd0, 0);
    chk("mult_wrap_val", 64'({mc[0], mc[6]}), 64'd0);

    // Full-size transpose.
    for (int q = 0; q < 25; q++) ma[q] = DW'(q);
    run_cmd("trans5", TRANS, 5, 8'd0, 0);
    chk("trans5_vals", 64'({mc[1], mc[5], mc[23]}), 64'({8'd5, 8'd1, 8'd19}));

    // Rejected commands.
    run_cmd("rej_sz0", ADD, 0, 8'd0, 0);
    run_cmd("rej_sz6", SUB, 6, 8'd0, 0);
    run_cmd("rej_sz7", MULT, 7, 8'd0, 0);
    run_cmd("rej_det", DET, 3, 8'd0, 0);

    // Random commands.
    for (int t = 0; t < 12; t++) begin
      int r = $urandom_range(0, 6);
      fill_rand();
      run_cmd("rand", 3'((r >= 4) ? r + 1 : r), $urandom_range(1, 5), DW'($urandom), 0);
    end

    // start pulsed during busy.
    fill_rand();
    run_cmd("poke", ADD, 4, 8'd0, 1);

    // Reset in the middle of a 5x5 mult, inside the third element.
    fill_rand();
    w0 = wr_total;
    op = MULT; size = 3'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (24) @(negedge clk);
    rst_n = 1'b0;
    ec[0] = mult_elem(0, 0, 5);
    ec[1] = mult_elem(0, 1, 5);
    dirty = 0;
    repeat (2) @(negedge clk) if (outs !== '0) dirty = 1;
    rst_n = 1'b1;
    repeat (5) @(negedge clk) if (outs !== '0) dirty = 1;
    chk("abort_outs", 64'(dirty), 64'd0);
    chk("abort_writes", 64'(wr_total - w0), 64'd2);
    cyc = 0;
    for (int q = 0; q < 32; q++) if (mc[q] !== ec[q]) cyc++;
    chk("abort_cmem", 64'(cyc), 64'd0);

    // Recovery after abort.
    fill_rand();
    run_cmd("after_abort", OPP, 3, 8'd0, 0);
    fill_rand();
    run_cmd("clr4", CLR, 4, 8'd0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
